// File: rtl/cook_timer_seq.sv
// cook_timer_seq: IDLE/RUN/PAUSE/ALARM sequencer for the kitchen cook timer.
// Drives the load/decrement/clear strobes of the set and count datapath,
// the display select, a pulsed alarm buzzer and the one-hot status LEDs.
module cook_timer_seq #(
  parameter int unsigned ALARM_SEC = 10,
  parameter int unsigned BEEP_MS   = 250
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       start_pe,
  input  logic       clear_pe,
  input  logic       any_btn_pe,
  input  logic       tick_msec,
  input  logic       tick_sec,
  input  logic       set_zero,
  input  logic       count_zero,
  output logic       load_en,
  output logic       count_tick,
  output logic       set_en,
  output logic       set_clear,
  output logic       show_count,
  output logic       alarm,
  output logic       buzzer,
  output logic [3:0] state_led
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [7:0] ASEC_LAST = 8'(ALARM_SEC);
  localparam logic [9:0] BEEP_LAST = 10'(BEEP_MS);

  state_t     state;
  state_t     state_nxt;
  logic       load_nxt;
  logic       clear_nxt;
  logic [7:0] asec_cnt;
  logic [9:0] beep_cnt;
  logic       asec_done;

  // Alarm times out on the tick that brings the second count up to ALARM_SEC.
  assign asec_done = tick_sec && ((asec_cnt + 8'd1) == ASEC_LAST);

  // Decrement strobe is combinational so a counter already at zero is never stepped.
  assign count_tick = tick_sec & (state == RUN) & ~load_en & ~count_zero;

  // Next-state and one-cycle strobe decisions.
  always_comb begin
    state_nxt = state;
    load_nxt  = 1'b0;
    clear_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clear_pe) begin
          clear_nxt = 1'b1;
        end else if (start_pe && !set_zero) begin
          state_nxt = RUN;
          load_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (clear_pe) begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end else if (count_zero && !load_en) begin
          // count_zero is stale while the load is in flight, so it is ignored then
          state_nxt = ALARM;
        end else if (start_pe) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (clear_pe) begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end else if (start_pe) begin
          state_nxt = RUN;
        end
      end
      default: begin
        if (any_btn_pe || asec_done) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // State register, registered status outputs and alarm second/beep counters.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state      <= IDLE;
      load_en    <= 1'b0;
      set_clear  <= 1'b0;
      alarm      <= 1'b0;
      buzzer     <= 1'b0;
      set_en     <= 1'b1;
      show_count <= 1'b0;
      state_led  <= 4'b0001;
      asec_cnt   <= '0;
      beep_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      load_en    <= load_nxt;
      set_clear  <= clear_nxt;
      alarm      <= (state_nxt == ALARM);
      set_en     <= (state_nxt == IDLE);
      show_count <= (state_nxt != IDLE);
      case (state_nxt)
        IDLE:    state_led <= 4'b0001;
        RUN:     state_led <= 4'b0010;
        PAUSE:   state_led <= 4'b0100;
        default: state_led <= 4'b1000;
      endcase

      if (state_nxt == ALARM && state != ALARM) begin
        asec_cnt <= '0;
        beep_cnt <= '0;
        buzzer   <= 1'b1;
      end else if (state_nxt == ALARM) begin
        if (tick_sec) begin
          asec_cnt <= asec_cnt + 8'd1;
        end
        if (tick_msec) begin
          if ((beep_cnt + 10'd1) == BEEP_LAST) begin
            beep_cnt <= '0;
            buzzer   <= ~buzzer;
          end else begin
            beep_cnt <= beep_cnt + 10'd1;
          end
        end
      end else begin
        asec_cnt <= '0;
        beep_cnt <= '0;
        buzzer   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cook_timer_seq.md
# cook_timer_seq

Sequencing controller for the kitchen cook timer. It owns the IDLE/RUN/PAUSE/ALARM state machine and drives the load, count-enable and set-clear strobes of the loadable BCD down-counters and the set-time up-counters. It also drives the display select, a pulsed buzzer and the status LEDs. It sits between the button edge detectors and clock dividers on one side and the set/count datapath and FND/buzzer outputs on the other.

## Interface
- ALARM_SEC, 10: alarm auto-off time in seconds (1..255)
- BEEP_MS, 250: buzzer on/off half-period in milliseconds (1..1023)

- clk  in  1  system clock
- reset_p  in  1  synchronous, active-high reset
- start_pe  in  1  start/pause button, one-cycle pulse
- clear_pe  in  1  clear button, one-cycle pulse
- any_btn_pe  in  1  OR of all button pulses (alarm acknowledge)
- tick_msec  in  1  one-cycle pulse per ms
- tick_sec  in  1  one-cycle pulse per s
- set_zero  in  1  set time == 00:00
- count_zero  in  1  down-counter value == 00:00
- load_en  out  1  load set time into down-counters, one-cycle pulse
- count_tick  out  1  decrement strobe to down-counters
- set_en  out  1  set-time increment buttons allowed
- set_clear  out  1  clear set-time counters, one-cycle pulse
- show_count  out  1  display mux: 1 = count time, 0 = set time
- alarm  out  1  alarm active
- buzzer  out  1  pulsed buzzer drive
- state_led  out  4  one-hot state {ALARM, PAUSE, RUN, IDLE}

## Operation
- States: IDLE, RUN, PAUSE, ALARM. The state is a registered, binary-encoded value.
- IDLE:
  - start_pe with !set_zero -> RUN, with load_en pulsed.
  - start_pe with set_zero is ignored.
  - clear_pe -> stay in IDLE, with set_clear pulsed.
- RUN: priority is clear_pe > count_zero > start_pe.
  - clear_pe -> IDLE, with set_clear pulsed.
  - count_zero (ignored in the load_en cycle) -> ALARM.
  - start_pe -> PAUSE.
- PAUSE:
  - clear_pe -> IDLE, with set_clear pulsed (clear has priority).
  - start_pe -> RUN. There is no reload; the count resumes.
- ALARM:
  - any_btn_pe -> IDLE.
  - The alarm second counter reaching ALARM_SEC -> IDLE.
  - start_pe/clear_pe in ALARM only acknowledge; they do not restart or clear.
- count_tick = tick_sec & (state==RUN) & !load_en & !count_zero. It is combinational, so the counter never decrements past zero.
- set_en = (state==IDLE). show_count = (state != IDLE).
- Alarm second counter (8 bit):
  - Cleared on ALARM entry.
  - Increments on tick_sec while in ALARM.
  - Exit on the tick that makes it equal ALARM_SEC.
- Beep counter (10 bit):
  - On ALARM entry, buzzer=1 and the counter is cleared.
  - Each tick_msec increments the counter. On reaching BEEP_MS, buzzer toggles and the counter clears.
  - buzzer=0 outside ALARM.
- alarm = (state==ALARM).
- reset_p in any state:
  - Next edge: state=IDLE, all counters 0.
  - Reset values: load_en=0, set_clear=0, buzzer=0, alarm=0, state_led=4'b0001, set_en=1, show_count=0, count_tick=0.

## Timing
- start_pe in cycle N (IDLE, !set_zero):
  - Cycle N+1: state=RUN and load_en=1.
  - Cycle N+2: load_en=0 and count_zero reflects the loaded value.
- The RUN->ALARM check uses count_zero only when load_en=0. This prevents a stale zero from the previous run triggering a false alarm.
- clear_pe in cycle N: set_clear=1 in cycle N+1 only, and state=IDLE from N+1.
- Last count_tick at 00:01 -> counter reads 00:00 one cycle later. ALARM is entered on the following edge (≤2 cycles after the tick).
- ALARM duration: exit on the ALARM_SEC-th tick_sec after entry, 1 cycle after that tick.
- Buzzer period is 2·BEEP_MS ms. The first toggle occurs on the BEEP_MS-th tick_msec after entry.
- Simultaneous start_pe and clear_pe: clear wins in every state except ALARM, where both act as acknowledge.
- Every state change, load_en and set_clear take effect one clock after the causing input pulse.

## Test plan
- Reset: assert reset_p 2 cycles from RUN -> state_led=0001, alarm=0, buzzer=0, load_en=0, show_count=0 on the next edge.
- Start with set_zero=1 -> state stays IDLE and load_en never pulses. Then set_zero=0 plus start_pe -> one-cycle load_en, state_led=0010.
- Run 00:03 with count_zero model:
  - Three count_tick pulses, then ALARM.
  - count_zero=1 held during the load_en cycle does not trigger ALARM.
- Pause/resume:
  - start_pe in RUN -> PAUSE, and count_tick stays 0 across 5 tick_sec.
  - start_pe -> RUN with no load_en.
- Clear priority: start_pe and clear_pe in the same cycle in PAUSE -> IDLE, set_clear high exactly 1 cycle.
- Alarm (ALARM_SEC=3, BEEP_MS=2):
  - buzzer toggles every 2 tick_msec, starting at 1.
  - Auto-exit to IDLE after the 3rd tick_sec.
  - Repeat with any_btn_pe at tick 1 -> immediate exit, buzzer=0.
